// File: rtl/rlc_pkg.sv
// Shared constants and FSM encoding for the packed run-length (RLC) stream.
// Both the encoder and the decoder use this package.
package rlc_pkg;

    localparam int VAL_W  = 4;
    localparam int RUN_W  = 2;
    localparam int WORD_W = 16;
    localparam int N_VALS = 8;
    localparam int SYM_W  = VAL_W + RUN_W;
    localparam int IN_W   = N_VALS * VAL_W;
    localparam int BUF_W  = 32;
    localparam int FILL_W = 6;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } rlc_state_e;

    // The run field holds run-1, so a run of 4 fits in two bits.
    function automatic logic [SYM_W-1:0] make_sym(input logic [VAL_W-1:0] v,
                                                  input logic [RUN_W:0]   run);
        return {v, RUN_W'(run - 1'b1)};
    endfunction

endpackage

// File: rtl/rlc_encoder_if.sv
// SRAM write port: one packed word per valid/ready transfer.
interface rlc_encoder_if;
    import rlc_pkg::*;

    logic [WORD_W-1:0] sram_dout;
    logic              sram_wvalid;
    logic              sram_wready;

    modport master (output sram_dout, output sram_wvalid, input  sram_wready);
    modport slave  (input  sram_dout, input  sram_wvalid, output sram_wready);

endinterface

// File: rtl/rlc_bit_packer.sv
// Packs 6-bit symbols MSB-first into a left-justified bit buffer and drains
// it to SRAM one 16-bit word at a time; a flush emits the zero-padded tail.
module rlc_bit_packer
    import rlc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_flush,
    input  logic             i_sym_valid,
    input  logic [SYM_W-1:0] i_sym_data,
    output logic             o_sym_ready,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_word_cnt,
    rlc_encoder_if.master    wr
);

    localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] SYM_BITS  = FILL_W'(SYM_W);
    localparam logic [FILL_W-1:0] SYM_TOP   = FILL_W'(BUF_W - SYM_W);

    logic [BUF_W-1:0]  r_buf;
    logic [FILL_W-1:0] r_fill;
    logic [CNT_W-1:0]  r_word_cnt;

    logic              w_full;
    logic              w_wvalid;
    logic              w_xfer;
    logic              w_append;
    logic [BUF_W-1:0]  w_buf_base;
    logic [FILL_W-1:0] w_fill_base;
    logic [BUF_W-1:0]  w_sym_ext;

    assign w_full      = r_fill >= WORD_BITS;
    assign w_wvalid    = w_full || (i_flush && (r_fill != '0));
    assign w_xfer      = w_wvalid && wr.sram_wready;
    // A pending word blocks new symbols unless it leaves in this same cycle.
    assign o_sym_ready = !w_full || wr.sram_wready;
    assign w_append    = i_sym_valid && o_sym_ready;

    // Drain first, then place the new symbol just below the surviving bits.
    always_comb begin
        w_buf_base  = r_buf;
        w_fill_base = r_fill;
        if (w_xfer) begin
            w_buf_base  = r_buf << WORD_W;
            w_fill_base = w_full ? (r_fill - WORD_BITS) : '0;
        end
        w_sym_ext = BUF_W'(i_sym_data) << (SYM_TOP - w_fill_base);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            // NOTE: the buffer is cleared, not just the fill count, because the
            // zero padding of the last word relies on unused bits being zero.
            r_buf      <= '0;
            r_fill     <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_append) begin
                r_buf  <= w_buf_base | w_sym_ext;
                r_fill <= w_fill_base + SYM_BITS;
            end else begin
                r_buf  <= w_buf_base;
                r_fill <= w_fill_base;
            end
            if (w_xfer) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign wr.sram_dout   = r_buf[BUF_W-1 -: WORD_W];
    assign wr.sram_wvalid = w_wvalid;
    assign o_empty        = (r_fill == '0);
    assign o_word_cnt     = r_word_cnt;

endmodule

// File: rtl/rlc_encoder.sv
// Run-length encoder: scans eight nibbles MSB first, merges equal neighbours
// into (value, run-1) symbols and hands them to the bit packer.
module rlc_encoder
    import rlc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IN_W-1:0]  in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt,
    rlc_encoder_if.master    sram
);

    localparam logic [RUN_W:0]   MAX_RUN  = (RUN_W + 1)'(1 << RUN_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VALS);

    rlc_state_e       r_state;
    logic [IN_W-1:0]  r_data;
    logic [VAL_W-1:0] r_cur;
    logic [RUN_W:0]   r_run;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_match;
    logic             w_sym_valid;
    logic             w_sym_ready;
    logic             w_empty;
    logic             w_flush;
    logic [VAL_W-1:0] w_nib;
    logic [SYM_W-1:0] w_sym;

    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_nib       = r_data[IN_W-1 -: VAL_W];
    // r_idx == N_VALS is the extra SCAN cycle that emits the final run.
    assign w_last      = (r_idx == LAST_IDX);
    assign w_match     = !w_last && (w_nib == r_cur) && (r_run < MAX_RUN);
    assign w_sym_valid = (r_state == ST_SCAN) && !w_match;
    assign w_sym       = make_sym(r_cur, r_run);
    assign w_flush     = (r_state == ST_FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_cur   <= '0;
            r_run   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_cur   <= in[IN_W-1 -: VAL_W];
                        r_data  <= in << VAL_W;
                        r_run   <= (RUN_W + 1)'(1);
                        r_idx   <= IDX_W'(1);
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (w_sym_ready) begin
                        if (w_last) begin
                            r_state <= ST_FLUSH;
                        end else begin
                            if (w_match) begin
                                r_run <= r_run + 1'b1;
                            end else begin
                                r_cur <= w_nib;
                                r_run <= (RUN_W + 1)'(1);
                            end
                            r_data <= r_data << VAL_W;
                            r_idx  <= r_idx + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_empty) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rlc_bit_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_accept),
        .i_flush     (w_flush),
        .i_sym_valid (w_sym_valid),
        .i_sym_data  (w_sym),
        .o_sym_ready (w_sym_ready),
        .o_empty     (w_empty),
        .o_word_cnt  (word_cnt),
        .wr          (sram)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_rlc_encoder.sv
// Directed bench for rlc_encoder: expected SRAM words are hand-computed, and
// a small reference decoder checks that the words reproduce the input.
module tb_rlc_encoder;
    import rlc_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] in_vec;
    logic        busy;
    logic        done;
    logic [3:0]  word_cnt;

    rlc_encoder_if sram_if ();

    rlc_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in       (in_vec),
        .busy     (busy),
        .done     (done),
        .word_cnt (word_cnt),
        .sram     (sram_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] got_q[$];
    int          done_cnt  = 0;
    int          stall_obs = 0;
    logic        prev_pending = 1'b0;
    logic [15:0] prev_dout    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decoder over up to three words: (value, run-1) symbols, MSB first.
    function automatic logic [31:0] decode(input logic [47:0] bits);
        logic [31:0] r;
        logic [3:0]  v;
        int          n;
        int          pos;
        int          run;
        r   = '0;
        n   = 0;
        pos = 47;
        while (n < 8 && pos >= 5) begin
            v   = bits[pos -: 4];
            run = int'(bits[pos-4 -: 2]) + 1;
            for (int k = 0; k < run && n < 8; k++) begin
                r[31-4*n -: 4] = v;
                n++;
            end
            pos -= 6;
        end
        return r;
    endfunction

    // Monitor on the falling edge: record transfers, check hold-while-stalled.
    always @(negedge clk) begin
        if (reset) begin
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                check("hold_valid", 32'(sram_if.sram_wvalid), 32'd1);
                check("hold_dout", 32'(sram_if.sram_dout), 32'(prev_dout));
            end
            if (sram_if.sram_wvalid && sram_if.sram_wready) got_q.push_back(sram_if.sram_dout);
            if (sram_if.sram_wvalid && !sram_if.sram_wready) stall_obs++;
            if (done) done_cnt++;
            prev_pending = sram_if.sram_wvalid && !sram_if.sram_wready;
            prev_dout    = sram_if.sram_dout;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_dout"},   32'(sram_if.sram_dout),   32'h0);
        check({tag, "_wvalid"}, 32'(sram_if.sram_wvalid), 32'h0);
        check({tag, "_busy"},   32'(busy),                32'h0);
        check({tag, "_done"},   32'(done),                32'h0);
        check({tag, "_wcnt"},   32'(word_cnt),            32'h0);
    endtask

    task automatic run_case(input string tag, input logic [31:0] vec, input bit stall,
                            input int inject_at, input int nwords,
                            input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        int          stall_cnt;
        bit          seen_done;
        logic [15:0] exp_w[3];
        logic [15:0] w[3];
        stall_cnt = 0;
        seen_done = 1'b0;
        exp_w     = '{e0, e1, e2};
        got_q.delete();
        done_cnt  = 0;
        stall_obs = 0;

        @(posedge clk); #1;
        start  = 1'b1;
        in_vec = vec;
        @(posedge clk); #1;
        start  = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);

        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            if (cyc == inject_at) begin
                start  = 1'b1;
                in_vec = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            if (stall && sram_if.sram_wvalid) begin
                if (stall_cnt < 5) begin
                    sram_if.sram_wready = 1'b0;
                    stall_cnt++;
                end else begin
                    sram_if.sram_wready = 1'b1;
                    stall_cnt = 0;
                end
            end else begin
                sram_if.sram_wready = 1'b1;
            end
            @(posedge clk); #1;
            seen_done = done;
        end
        start               = 1'b0;
        sram_if.sram_wready = 1'b1;

        check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        check({tag, "_done_dropped"}, 32'(done), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_nwords"}, 32'(got_q.size()), 32'(nwords));
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'(nwords));
        for (int i = 0; i < 3; i++) begin
            w[i] = (i < got_q.size()) ? got_q[i] : 16'h0000;
            if (i < nwords) check($sformatf("%s_word%0d", tag, i), 32'(w[i]), 32'(exp_w[i]));
        end
        check({tag, "_loopback"}, decode({w[0], w[1], w[2]}), vec);
        if (stall) check({tag, "_stall_cycles"}, 32'(stall_obs), 32'd15);
    endtask

    initial begin
        reset               = 1'b1;
        start               = 1'b0;
        in_vec              = '0;
        sram_if.sram_wready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b0;

        run_case("c1_mixed",   32'h2300_0001, 1'b0, -1, 2, 16'h20C0, 16'hC010, 16'h0000);
        run_case("c2_runs",    32'h7777_7777, 1'b0, -1, 1, 16'h7DF0, 16'h0000, 16'h0000);
        run_case("c3_full",    32'h0123_4567, 1'b0, -1, 3, 16'h0042, 16'h0C41, 16'h461C);
        run_case("c4_stall",   32'h0123_4567, 1'b1, -1, 3, 16'h0042, 16'h0C41, 16'h461C);

        // Abort case 1 mid-scan with a one-cycle reset.
        got_q.delete();
        @(posedge clk); #1;
        start  = 1'b1;
        in_vec = 32'h2300_0001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_values("mid_reset");
        repeat (6) @(posedge clk);
        #1;
        check("mid_reset_no_stray", 32'(got_q.size()), 32'd0);
        check("mid_reset_idle_wcnt", 32'(word_cnt), 32'd0);
        run_case("c5_after_rst", 32'h7777_7777, 1'b0, -1, 1, 16'h7DF0, 16'h0000, 16'h0000);

        run_case("c6_inject",  32'h0123_4567, 1'b0, 2, 3, 16'h0042, 16'h0C41, 16'h461C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
